keypad_entry_buffer: RTL and testbench

- Parametrised successor to the keypad encoder / T-FF clock divider / shift-register-array chain.
- Samples a one-hot keypad vector on a single clock and debounces each press.
- Commits each press as exactly one BCD digit into an N-digit entry shift array.
- Presents the completed entry to downstream logic through a valid/ready handshake on "enter".

---
 rtl/keypad_entry_buffer_pkg.sv | 38 +++
 rtl/keypad_entry_buffer_key_debouncer.sv | 85 ++++++++
 rtl/keypad_entry_buffer.sv | 96 +++++++++
 tb/tb_keypad_entry_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_buffer_pkg.sv
// Shared types and helpers for the keypad entry buffer: FSM encodings,
// overflow policy constants and the one-hot key encoder.
package keypad_entry_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } deb_state_t;

  localparam logic OVW_DROP  = 1'b0;
  localparam logic OVW_SHIFT = 1'b1;

  // Encoder input is sized for the widest supported keypad; callers zero-pad.
  localparam int MAX_KEYS = 32;
  localparam int CODE_W   = 5;

  typedef struct packed {
    logic              is_single;
    logic [CODE_W-1:0] code;
  } onehot_res_t;

  function automatic onehot_res_t onehot_to_code(input logic [MAX_KEYS-1:0] vec);
    onehot_res_t res;
    int unsigned ones;
    res  = '0;
    ones = 32'd0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (vec[i]) begin
        ones     = ones + 32'd1;
        res.code = CODE_W'(i);
      end
    end
    res.is_single = (ones == 32'd1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_key_debouncer.sv
// Per-press debouncer: latches a single pressed key, requires it to stay
// stable for DEBOUNCE_CYC edges, then emits exactly one commit per press.
module keypad_entry_buffer_key_debouncer
  import keypad_entry_buffer_pkg::*;
#(
  parameter int NUM_KEYS     = 10,
  parameter int DIGIT_W      = 4,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                hold,
  input  logic [NUM_KEYS-1:0] key,
  output logic                commit_pulse,
  output logic [DIGIT_W-1:0]  commit_code,
  output logic                multi_key_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  deb_state_t          state;
  deb_state_t          next_state;
  logic [DB_W-1:0]     cnt;
  logic [NUM_KEYS-1:0] latched_key;
  logic [DIGIT_W-1:0]  latched_code;
  logic [MAX_KEYS-1:0] key_ext;
  onehot_res_t         dec;
  logic                match;
  logic                cnt_done;
  logic                blocked;

  always_comb begin
    key_ext                 = '0;
    key_ext[NUM_KEYS-1:0]   = key;
    dec                     = onehot_to_code(key_ext);
    match                   = (key == latched_key);
    cnt_done                = (cnt == DB_W'(DEBOUNCE_CYC - 1));
    blocked                 = clear | hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     next_state = dec.is_single ? ST_DEBOUNCE : ST_IDLE;
      ST_DEBOUNCE: begin
        if (!match)        next_state = ST_IDLE;
        else if (cnt_done) next_state = ST_HELD;
        else               next_state = ST_DEBOUNCE;
      end
      ST_HELD:     next_state = (key == '0) ? ST_IDLE : ST_HELD;
      default:     next_state = ST_IDLE;
    endcase
    // Flush or a published entry pins the FSM in IDLE.
    if (blocked) next_state = ST_IDLE;
  end

  always_comb begin
    commit_pulse    = !blocked && (state == ST_DEBOUNCE) && match && cnt_done;
    multi_key_pulse = !blocked && (state == ST_IDLE) && (key != '0) && !dec.is_single;
    commit_code     = latched_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      latched_key  <= '0;
      latched_code <= '0;
    end else if (blocked) begin
      cnt          <= '0;
    end else if (state == ST_IDLE && dec.is_single) begin
      cnt          <= '0;
      latched_key  <= key;
      latched_code <= DIGIT_W'(dec.code);
    end else if (state == ST_DEBOUNCE && match) begin
      cnt          <= cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: debounced key presses shift BCD digits into an
// N-digit array, published downstream through a valid/ready handshake.
module keypad_entry_buffer
  import keypad_entry_buffer_pkg::*;
#(
  parameter int   NUM_KEYS     = 10,
  parameter int   NUM_DIGITS   = 4,
  parameter int   DIGIT_W      = 4,
  parameter int   DEBOUNCE_CYC = 3,
  parameter logic OVERWRITE    = OVW_DROP,
  localparam int  CNT_W        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_ui,
  input  logic [NUM_KEYS-1:0]           key,
  input  logic                          clear,
  input  logic                          enter,
  input  logic                          out_ready,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [CNT_W-1:0]              count,
  output logic                          full,
  output logic                          out_valid,
  output logic                          key_err
);

  localparam int ARR_W = NUM_DIGITS * DIGIT_W;
  typedef logic [ARR_W-1:0] arr_t;

  logic               commit_pulse;
  logic [DIGIT_W-1:0] commit_code;
  logic               multi_key_pulse;
  arr_t               next_digits;
  logic [CNT_W-1:0]   next_count;
  logic               reject;

  keypad_entry_buffer_key_debouncer #(
    .NUM_KEYS     (NUM_KEYS),
    .DIGIT_W      (DIGIT_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_deb (
    .clk             (clk),
    .rst             (rst_ui),
    .clear           (clear),
    .hold            (out_valid),
    .key             (key),
    .commit_pulse    (commit_pulse),
    .commit_code     (commit_code),
    .multi_key_pulse (multi_key_pulse)
  );

  assign full = (count == CNT_W'(NUM_DIGITS));

  // Shifting left by one digit drops the oldest (top) slot automatically.
  always_comb begin
    next_digits = digits;
    next_count  = count;
    reject      = 1'b0;
    if (commit_pulse) begin
      if (!full) begin
        next_digits = (digits << DIGIT_W) | arr_t'(commit_code);
        next_count  = count + CNT_W'(1);
      end else if (OVERWRITE == OVW_SHIFT) begin
        next_digits = (digits << DIGIT_W) | arr_t'(commit_code);
      end else begin
        reject      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_ui) begin
    if (rst_ui) begin
      digits    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      key_err   <= 1'b0;
    end else if (clear) begin
      digits    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      key_err   <= 1'b0;
    end else if (out_valid) begin
      key_err <= 1'b0;
      if (out_ready) begin
        out_valid <= 1'b0;
        digits    <= '0;
        count     <= '0;
      end
    end else begin
      digits    <= next_digits;
      count     <= next_count;
      key_err   <= reject | multi_key_pulse;
      out_valid <= enter && (next_count != '0);
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench for keypad_entry_buffer: expected commits/errors are queued
// from a reference model and matched against events seen on the outputs.
module tb_keypad_entry_buffer;

  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst_ui;
  logic [9:0]  key;
  logic        clear, enter, out_ready;
  logic [15:0] digits, digits_o;
  logic [2:0]  count, count_o;
  logic        full, full_o, out_valid, out_valid_o, key_err, key_err_o;

  keypad_entry_buffer #(.NUM_KEYS(10), .NUM_DIGITS(4), .DIGIT_W(4),
                        .DEBOUNCE_CYC(DEB), .OVERWRITE(1'b0)) dut (
    .clk(clk), .rst_ui(rst_ui), .key(key), .clear(clear), .enter(enter),
    .out_ready(out_ready), .digits(digits), .count(count), .full(full),
    .out_valid(out_valid), .key_err(key_err));

  keypad_entry_buffer #(.NUM_KEYS(10), .NUM_DIGITS(4), .DIGIT_W(4),
                        .DEBOUNCE_CYC(DEB), .OVERWRITE(1'b1)) dut_ovw (
    .clk(clk), .rst_ui(rst_ui), .key(key), .clear(clear), .enter(enter),
    .out_ready(out_ready), .digits(digits_o), .count(count_o), .full(full_o),
    .out_valid(out_valid_o), .key_err(key_err_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  exp_err_q[$];
  int  err_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] m_digits = 16'h0;
  logic [2:0]  m_count = 3'd0;
  logic [15:0] prev_d = 16'h0;
  logic [2:0]  prev_c = 3'd0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: record every change of the entry and every key_err cycle.
  always @(negedge clk) begin
    if (digits !== prev_d || count !== prev_c) begin
      obs_q.push_back('{d: digits, c: count, cyc: cyc});
      prev_d = digits;
      prev_c = count;
    end
    if (key_err === 1'b1) err_q.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference model of a commit (OVERWRITE=0 instance); key press starts next edge.
  task automatic model_press(input int code);
    int at;
    at = cyc + 1 + DEB;
    if (m_count < 3'd4) begin
      m_digits = (m_digits << 4) | 16'(code);
      m_count  = m_count + 3'd1;
      exp_q.push_back('{d: m_digits, c: m_count, cyc: at});
    end else begin
      exp_err_q.push_back(at);
    end
  endtask

  task automatic press(input int code, input int hold);
    key = 10'd1 << code;
    repeat (hold) @(negedge clk);
    key = 10'd0;
    @(negedge clk);
  endtask

  task automatic flush();
    @(negedge clk);
    obs_q.delete();
    err_q.delete();
    exp_q.delete();
    exp_err_q.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_digits = 16'h0;
    m_count  = 3'd0;
    flush();
  endtask

  task automatic drain(input string name);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: no commit seen, expected digits=%h count=%0d at edge %0d", name, e.d, e.c, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.d !== e.d || o.c !== e.c || o.cyc != e.cyc) begin
          miscompares++;
          $display("FAIL %s: got digits=%h count=%0d edge=%0d, expected digits=%h count=%0d edge=%0d",
                   name, o.d, o.c, o.cyc, e.d, e.c, e.cyc);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d unexpected entry changes, first digits=%h", name, obs_q.size(), obs_q[0].d);
    end
    vectors++;
    if (err_q != exp_err_q) begin
      miscompares++;
      $display("FAIL %s_err: key_err cycles %p, expected %p", name, err_q, exp_err_q);
    end
    obs_q.delete();
    err_q.delete();
    exp_err_q.delete();
  endtask

  task automatic test_reset();
    rst_ui = 1'b1; key = 10'd0; clear = 1'b0; enter = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_ui = 1'b0;
    vectors++;
    if ({digits, count, full, out_valid, key_err} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset: digits=%h count=%0d full=%b ov=%b err=%b, expected all 0",
               digits, count, full, out_valid, key_err);
    end
    flush();
  endtask

  task automatic test_clean_presses();
    int codes[4] = '{2, 1, 9, 7};
    foreach (codes[i]) begin
      model_press(codes[i]);
      press(codes[i], 6);
    end
    drain("clean_presses");
    vectors++;
    if (digits !== 16'h2197 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL clean_final: digits=%h full=%b, expected 2197 full=1", digits, full);
    end
  endtask

  task automatic test_overflow();
    model_press(3);
    press(3, 6);
    drain("overflow_drop");
    vectors++;
    if (digits_o !== 16'h1973 || count_o !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow_shift: digits=%h count=%0d, expected 1973 count=4", digits_o, count_o);
    end
    do_clear();
  endtask

  task automatic test_bounce();
    key = 10'd1 << 5;
    repeat (2) @(negedge clk);
    key = 10'd0;
    @(negedge clk);
    model_press(5);
    press(5, 5);
    drain("bounce");
    vectors++;
    if (count !== 3'd1 || digits !== 16'h0005) begin
      miscompares++;
      $display("FAIL bounce_final: digits=%h count=%0d, expected 0005 count=1", digits, count);
    end
  endtask

  task automatic test_multi_key();
    exp_err_q.push_back(cyc + 1);
    key = 10'b0000001010;
    @(negedge clk);
    key = 10'd0;
    repeat (5) @(negedge clk);
    drain("multi_key");
    vectors++;
    if (dut.u_deb.state !== 2'd0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL multi_key_state: state=%0d count=%0d, expected IDLE count=1", dut.u_deb.state, count);
    end
    do_clear();
  endtask

  task automatic test_handshake();
    model_press(4);
    press(4, 4);
    model_press(2);
    press(2, 4);
    drain("hs_entry");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || digits !== 16'h0042 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL hs_idle_ready: ov=%b digits=%h count=%0d, expected 0 0042 2", out_valid, digits, count);
    end
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_publish: out_valid=%b, expected 1", out_valid);
    end
    obs_q.delete();
    press(8, 6);
    drain("hs_frozen");
    vectors++;
    if (out_valid !== 1'b1 || digits !== 16'h0042 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL hs_hold: ov=%b digits=%h count=%0d, expected 1 0042 2", out_valid, digits, count);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || digits !== 16'h0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL hs_complete: ov=%b digits=%h count=%0d, expected 0 0000 0", out_valid, digits, count);
    end
    m_digits = 16'h0;
    m_count  = 3'd0;
    flush();
  endtask

  task automatic test_priority();
    // Clear lands on the very edge that would commit.
    key = 10'd1 << 6;
    repeat (DEB) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    key = 10'd0;
    repeat (4) @(negedge clk);
    vectors++;
    if (digits !== 16'h0 || count !== 3'd0 || key_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_vs_commit: digits=%h count=%0d err=%b, expected 0", digits, count, key_err);
    end
    flush();
    model_press(1);
    press(1, 4);
    drain("prio_entry");
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0 || digits !== 16'h0) begin
      miscompares++;
      $display("FAIL clear_vs_valid: ov=%b count=%0d digits=%h, expected 0", out_valid, count, digits);
    end
    m_digits = 16'h0;
    m_count  = 3'd0;
    flush();
    press(3, 4);
    key = 10'd1 << 7;
    repeat (2) @(negedge clk);
    #2 rst_ui = 1'b1;
    #1;
    vectors++;
    if (digits !== 16'h0 || count !== 3'd0 || dut.u_deb.state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_debounce: digits=%h count=%0d state=%0d, expected 0 0 IDLE",
               digits, count, dut.u_deb.state);
    end
    key = 10'd0;
    @(negedge clk);
    rst_ui = 1'b0;
    flush();
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enter_empty: out_valid=%b, expected 0", out_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_presses();
    test_overflow();
    test_bounce();
    test_multi_key();
    test_handshake();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
